mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port arbiter that shares the single memory bus (address, read strobe, 2-bit write code, 32-bit data) between the multi-cycle CPU (port 0) and a secondary master such as the DMA/display engine (port 1). It sits between the masters and the memory/bus adapter. Each transfer is a registered req/ack handshake, with fair round-robin between the ports and a parameterised fixed read latency.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `READ_LAT`, 1, cycles from the memory sampling `mem_read` to `mem_rdata` being valid. Legal range 1..7.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req[1:0]`  in  2  per-port request; held high until that port's ack.
- `op0[1:0]`, `op1[1:0]`  in  2 each  operation code: 0 = read, 1 = word write, 2 = DMA write, 3 = byte write.
- `addr0`, `addr1`  in  AW each  transfer address.
- `wdata0`, `wdata1`  in  DW each  write data.
- `ack[1:0]`  out  2  one-cycle completion pulse per port.
- `rdata0`, `rdata1`  out  DW each  read data; valid while that port's ack is high, held until that port's next read.
- `mem_addr`  out  AW  memory address.
- `mem_read`  out  1  read strobe.
- `mem_write[1:0]`  out  2  write code; same encoding as `op` (0 = none).
- `mem_wdata`  out  DW  write data.
- `mem_rdata`  in  DW  read data from memory.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states are IDLE, ISSUE, WAIT and DONE.
- IDLE:
  - Form the eligible set `req & ~ack`; a port is masked during its own ack cycle.
  - If the set is non-empty, the winner is chosen by round-robin: the port not granted last wins ties.
  - Latch the winner's addr/op/wdata and the grant index, then go to ISSUE.
- ISSUE lasts exactly one cycle.
  - Read: `mem_read`=1 and `mem_addr` driven; go to WAIT with the counter loaded to READ_LAT-1.
  - Write: `mem_write`=op, `mem_addr` and `mem_wdata` driven; go to DONE.
- WAIT: the counter decrements each cycle; go to DONE when it reaches 0.
  - With READ_LAT=1, WAIT is occupied for one cycle.
  - `mem_read` and `mem_write` are 0 in this state.
- DONE: for a read, capture `mem_rdata` into `rdataN`. Pulse `ack[N]` in the following cycle, update the last-grant pointer and return to IDLE.
- Only one transfer is outstanding at a time, and there is no pipelining.
- `mem_addr` and `mem_wdata` hold their last values when idle. The strobes are 0 outside ISSUE.
- A change of `op` or `addr` while `req` is held and not yet acked is ignored once the port has been latched.
- A requester dropping `req` before ack does not cancel the transfer; ack still pulses.

## Timing
- All outputs are registered.
- Reset values: `ack`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `rdata0`/`rdata1`=0, `busy`=0, state IDLE. The last-grant pointer resets so that port 0 wins the first tie.
- Example: `req` high before edge E0 (state IDLE).
  - The strobe is high in cycle E0→E1.
  - Write: ack is high in cycle E1→E2 (2 cycles).
  - Read: ack is high in cycle E(1+READ_LAT)→E(2+READ_LAT). With READ_LAT=1 this is cycle E2→E3 (3 cycles).
- A back-to-back request from the other port is granted in the ack cycle, so its strobe appears one cycle after that ack cycle.
- A port holding `req` continuously gets at most every other grant when the other port is also requesting.
- Reset asserted mid-transfer:
  - All state clears immediately.
  - The strobe drops asynchronously.
  - No ack is issued, and the outstanding transfer is lost.

## Structure
- Package `mem_bus_pkg`:
  - Op/write-code constants `MW_NONE`=0, `MW_WORD`=1, `MW_DMA`=2, `MW_BYTE`=3; read is `op` = 0.
  - The FSM state encoding.
- Sub-module `rr_arb2`: combinational 2-way round-robin picker taking the eligible vector and the last-grant bit, and returning the grant index and a valid flag.
- The top level holds the FSM, latency counter, latched request and output registers.

## Test plan
- Single CPU read, READ_LAT=1:
  - Stimulus: `req`=01, op0=0, addr0=0x10, and memory returns 0xDEADBEEF.
  - Required: `mem_read` for one cycle with `mem_addr`=0x10, then `ack`=01 3 cycles after the request, with `rdata0`=0xDEADBEEF.
- Single port-1 byte write:
  - Stimulus: op1=3, addr1=0x20, wdata1=0x5A.
  - Required: `mem_write`=3 for exactly one cycle with addr 0x20 and data 0x5A, then `ack`=10 in the next cycle.
- Simultaneous requests after reset:
  - Stimulus: `req`=11, both held through their acks.
  - Required: port 0 is served first and port 1 second. The order alternates 0,1,0,1 while both keep re-requesting; neither port gets two consecutive grants.
- READ_LAT=4:
  - Stimulus: a read.
  - Required: ack arrives exactly 6 cycles after the request, and data sampled at the correct edge matches memory.
- Reset mid-read:
  - Stimulus: `rst_n` pulled low while in WAIT.
  - Required: all outputs read 0 immediately and no ack appears. After release, a fresh `req` completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared constants and FSM encoding for the memory bus arbiter
//
// Purpose: op/write-code constants and arbiter state type.
// Ports:   none (package).
package mem_bus_pkg;

  // Write codes on mem_write; the same values are used as request op codes,
  // where 0 means read rather than "no write".
  localparam logic [1:0] MW_NONE = 2'd0;
  localparam logic [1:0] MW_WORD = 2'd1;
  localparam logic [1:0] MW_DMA  = 2'd2;
  localparam logic [1:0] MW_BYTE = 2'd3;
  localparam logic [1:0] OP_READ = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
//
// Purpose: pick one of two eligible ports, preferring the one not granted last.
// Ports:   elig_i  - eligible vector (bit N = port N)
//          last_i  - index of the port granted last
//          gnt_o   - chosen port index (meaningful only when valid_o)
//          valid_o - at least one port is eligible
module rr_arb2 (
  input  logic [1:0] elig_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       valid_o
);

  assign valid_o = |elig_i;
  // On a tie the port that did not win last time goes next; otherwise the
  // single eligible port wins.
  assign gnt_o   = (elig_i == 2'b11) ? ~last_i : elig_i[1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port req/ack arbiter onto a single memory bus
//
// Purpose: share one memory bus between the CPU (port 0) and a secondary master
//          (port 1), one transfer at a time, round-robin, fixed read latency.
// Ports:   clk, rst_n                 - clock, async active-low reset
//          req, ack                   - per-port request level / completion pulse
//          op0/op1, addr0/addr1,
//          wdata0/wdata1              - per-port transfer description
//          rdata0, rdata1             - per-port read data, held until next read
//          mem_addr, mem_read,
//          mem_write, mem_wdata       - memory bus outputs (registered)
//          mem_rdata                  - memory read data
//          busy                       - arbiter not idle
module mem_bus_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [1:0]    op0,
  input  logic [1:0]    op1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    ack,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic [1:0]    mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  import mem_bus_pkg::*;

  localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic          gnt_q;
  logic          rd_q;
  logic          last_q;
  logic [1:0]    ack_q;
  logic          mem_read_q;
  logic [1:0]    mem_write_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          busy_q;

  logic [1:0]    elig_d;
  logic          win_d;
  logic          win_valid_d;
  logic [1:0]    win_op_d;
  logic [AW-1:0] win_addr_d;
  logic [DW-1:0] win_wdata_d;

  // A port is not eligible during its own ack cycle, so a master that keeps
  // req high for a follow-on transfer cannot be re-granted immediately.
  assign elig_d = req & ~ack_q;

  rr_arb2 u_arb (
    .elig_i  (elig_d),
    .last_i  (last_q),
    .gnt_o   (win_d),
    .valid_o (win_valid_d)
  );

  assign win_op_d    = win_d ? op1    : op0;
  assign win_addr_d  = win_d ? addr1  : addr0;
  assign win_wdata_d = win_d ? wdata1 : wdata0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      gnt_q       <= 1'b0;
      rd_q        <= 1'b0;
      last_q      <= 1'b1;  // port 0 wins the first tie
      ack_q       <= 2'b00;
      mem_read_q  <= 1'b0;
      mem_write_q <= MW_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      // Strobes and ack are single-cycle pulses.
      ack_q       <= 2'b00;
      mem_read_q  <= 1'b0;
      mem_write_q <= MW_NONE;
      case (state_q)
        // DONE (the ack cycle) arbitrates like IDLE so the other port's
        // strobe can follow the ack directly.
        ST_IDLE, ST_DONE: begin
          if (win_valid_d) begin
            gnt_q      <= win_d;
            last_q     <= win_d;
            rd_q       <= (win_op_d == OP_READ);
            mem_addr_q <= win_addr_d;
            if (win_op_d == OP_READ) begin
              mem_read_q <= 1'b1;
            end else begin
              mem_write_q <= win_op_d;
              mem_wdata_q <= win_wdata_d;
            end
            state_q <= ST_ISSUE;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (rd_q) begin
            state_q <= ST_WAIT;
            cnt_q   <= LAT_M1;
          end else begin
            state_q <= ST_DONE;
            ack_q   <= gnt_q ? 2'b10 : 2'b01;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q <= ST_DONE;
            ack_q   <= gnt_q ? 2'b10 : 2'b01;
            if (gnt_q) rdata1_q <= mem_rdata;
            else       rdata0_q <= mem_rdata;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, req4;
  logic [1:0]  op0, op1;
  logic [31:0] addr0, addr1, wdata0, wdata1;

  logic [1:0]  ack, mem_write;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, busy;

  logic [1:0]  ack4, mem_write4;
  logic [31:0] rdata4_0, rdata4_1, mem_addr4, mem_wdata4, mem_rdata4;
  logic        mem_read4, busy4;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic        rd;
    logic [1:0]  wcode;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          at;
  } strobe_t;

  typedef struct {
    logic [1:0]  ackv;
    logic        rd;
    logic [31:0] rdata;
    int          at;
  } ack_t;

  strobe_t sq[$];
  ack_t    aq[$];
  strobe_t s_pop;
  ack_t    a_pop;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_arbiter #(.AW(32), .DW(32), .READ_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op0(op0), .op1(op1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata0(rdata0), .rdata1(rdata1), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_bus_arbiter #(.AW(32), .DW(32), .READ_LAT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .op0(op0), .op1(op1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack4), .rdata0(rdata4_0), .rdata1(rdata4_1), .mem_addr(mem_addr4),
    .mem_read(mem_read4), .mem_write(mem_write4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata4), .busy(busy4)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ((a * 32'h0101_0101) ^ 32'hA5A5_0000);
  endfunction

  // Memory models: data is valid only in the single cycle READ_LAT after the
  // strobe is sampled, garbage otherwise, so a wrong capture edge shows up.
  logic [2:0]  mcnt, mcnt4;
  logic [31:0] mdata, mdata4;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 3'd0; mcnt4 <= 3'd0; mdata <= 32'h0; mdata4 <= 32'h0;
    end else begin
      if (mem_read) begin mcnt <= 3'd1; mdata <= mem_fn(mem_addr); end
      else if (mcnt != 3'd0) mcnt <= mcnt - 3'd1;
      if (mem_read4) begin mcnt4 <= 3'd4; mdata4 <= mem_fn(mem_addr4); end
      else if (mcnt4 != 3'd0) mcnt4 <= mcnt4 - 3'd1;
    end
  end
  assign mem_rdata  = (mcnt  == 3'd1) ? mdata  : 32'hBAD0_BAD0;
  assign mem_rdata4 = (mcnt4 == 3'd1) ? mdata4 : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard monitor for the READ_LAT=1 instance.
  always @(negedge clk) begin
    if (mem_read || (mem_write != MW_NONE)) begin
      if (sq.size() == 0) begin
        check("strobe_unexpected", {mem_read, mem_write}, 0);
      end else begin
        s_pop = sq.pop_front();
        check("strobe_rd", mem_read, s_pop.rd);
        check("strobe_wcode", mem_write, s_pop.wcode);
        check("strobe_addr", mem_addr, s_pop.addr);
        if (!s_pop.rd) check("strobe_wdata", mem_wdata, s_pop.wdata);
        check("strobe_cycle", cyc, s_pop.at);
        check("strobe_busy", busy, 1);
      end
    end
    if (ack != 2'b00) begin
      if (aq.size() == 0) begin
        check("ack_unexpected", ack, 0);
      end else begin
        a_pop = aq.pop_front();
        check("ack_vec", ack, a_pop.ackv);
        check("ack_cycle", cyc, a_pop.at);
        if (a_pop.rd) check("ack_rdata", a_pop.ackv[1] ? rdata1 : rdata0, a_pop.rdata);
      end
    end
  end

  // Drives a transfer on port p (caller is at a negedge) and waits for its ack;
  // req is left high so the caller may chain another transfer or drop it.
  task automatic xfer(input int p, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] wd);
    int n = 0;
    if (p == 0) begin op0 = op; addr0 = a; wdata0 = wd; end
    else        begin op1 = op; addr1 = a; wdata1 = wd; end
    req[p] = 1'b1;
    do begin @(negedge clk); n++; end while (!ack[p] && n < 40);
    check($sformatf("ack_seen_p%0d", p), ack[p], 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sq.size() != 0 || aq.size() != 0) && n < 40) begin
      @(negedge clk); n++;
    end
    check("drain", sq.size() + aq.size(), 0);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t0, n;
    rst_n = 1'b0; req = 2'b00; req4 = 2'b00;
    op0 = 2'd0; op1 = 2'd0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single CPU read.
    t0 = cyc;
    sq.push_back('{1'b1, MW_NONE, 32'h10, 32'h0, t0 + 1});
    aq.push_back('{2'b01, 1'b1, 32'hDEADBEEF, t0 + 3});
    xfer(0, 2'd0, 32'h10, 32'h0);
    req[0] = 1'b0;
    drain();

    // Single port-1 byte write.
    t0 = cyc;
    sq.push_back('{1'b0, MW_BYTE, 32'h20, 32'h5A, t0 + 1});
    aq.push_back('{2'b10, 1'b0, 32'h0, t0 + 2});
    xfer(1, MW_BYTE, 32'h20, 32'h5A);
    req[1] = 1'b0;
    drain();

    // One port re-requesting alone: masked in its ack cycle, re-granted after.
    t0 = cyc;
    sq.push_back('{1'b0, MW_WORD, 32'h60, 32'h1234_5678, t0 + 1});
    aq.push_back('{2'b01, 1'b0, 32'h0, t0 + 2});
    sq.push_back('{1'b0, MW_DMA, 32'h64, 32'h9ABC_DEF0, t0 + 4});
    aq.push_back('{2'b01, 1'b0, 32'h0, t0 + 5});
    xfer(0, MW_WORD, 32'h60, 32'h1234_5678);
    xfer(0, MW_DMA, 32'h64, 32'h9ABC_DEF0);
    req[0] = 1'b0;
    drain();

    // Requester drops req right after the strobe; ack still arrives.
    t0 = cyc;
    sq.push_back('{1'b0, MW_WORD, 32'h70, 32'hCAFE_F00D, t0 + 1});
    aq.push_back('{2'b10, 1'b0, 32'h0, t0 + 2});
    op1 = MW_WORD; addr1 = 32'h70; wdata1 = 32'hCAFE_F00D; req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    drain();

    // Simultaneous requests after reset: alternation 0,1,0,1.
    pulse_reset();
    t0 = cyc;
    sq.push_back('{1'b1, MW_NONE, 32'h40, 32'h0, t0 + 1});
    aq.push_back('{2'b01, 1'b1, mem_fn(32'h40), t0 + 3});
    sq.push_back('{1'b0, MW_WORD, 32'h44, 32'h1111, t0 + 4});
    aq.push_back('{2'b10, 1'b0, 32'h0, t0 + 5});
    sq.push_back('{1'b0, MW_DMA, 32'h48, 32'h2222, t0 + 6});
    aq.push_back('{2'b01, 1'b0, 32'h0, t0 + 7});
    sq.push_back('{1'b1, MW_NONE, 32'h4C, 32'h0, t0 + 8});
    aq.push_back('{2'b10, 1'b1, mem_fn(32'h4C), t0 + 10});
    fork
      begin
        xfer(0, 2'd0, 32'h40, 32'h0);
        xfer(0, MW_DMA, 32'h48, 32'h2222);
        req[0] = 1'b0;
      end
      begin
        xfer(1, MW_WORD, 32'h44, 32'h1111);
        xfer(1, 2'd0, 32'h4C, 32'h0);
        req[1] = 1'b0;
      end
    join
    drain();
    check("rdata0_hold", rdata0, mem_fn(32'h40));

    // READ_LAT=4 instance.
    t0 = cyc;
    op0 = 2'd0; addr0 = 32'h80; req4 = 2'b01;
    n = 0;
    do begin @(negedge clk); n++; end while (ack4 == 2'b00 && n < 20);
    check("lat4_ack", ack4, 2'b01);
    check("lat4_cycles", cyc - t0, 6);
    check("lat4_rdata", rdata4_0, mem_fn(32'h80));
    req4 = 2'b00;
    repeat (2) @(negedge clk);

    // Reset asserted while the read is in WAIT.
    t0 = cyc;
    sq.push_back('{1'b1, MW_NONE, 32'h90, 32'h0, t0 + 1});
    op0 = 2'd0; addr0 = 32'h90; req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("wait_busy", busy, 1);
    check("wait_no_strobe", mem_read, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_ack", ack, 0);
    check("midrst_busy", busy, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_rdata0", rdata0, 0);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh request after reset completes normally.
    t0 = cyc;
    sq.push_back('{1'b1, MW_NONE, 32'hA0, 32'h0, t0 + 1});
    aq.push_back('{2'b01, 1'b1, mem_fn(32'hA0), t0 + 3});
    xfer(0, 2'd0, 32'hA0, 32'h0);
    req[0] = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
